// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
// Holds the FSM state encoding and the slice width.
package cla_seq_pkg;

  // Width of the single carry-lookahead slice that is reused every cycle.
  localparam int NIB_BITS = 4;

  // Sequencer states: wait for operands, walk the nibbles, hold the result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// Carries c1..c4 are formed directly from generate/propagate terms, so
// there is no ripple path inside the slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3, c4;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
    co = c4;
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder built from one reused 4-bit CLA slice,
// one nibble per clock, least significant nibble first.
// Optional macro CLA_SEQ_SUB_EN adds a 'sub' input for a-b.
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high
// only in DONE, and sum/cout stay frozen there until out_ready is seen.
// WIDTH must be a multiple of 4 and at least 8.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_BITS;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIB_BITS-1:0] slice_a, slice_b, slice_s;
  logic                slice_co;

  // Select the current nibble of each captured operand for the slice.
  always_comb begin
    slice_a = a_q[NIB_BITS*int'(idx_q) +: NIB_BITS];
    slice_b = b_q[NIB_BITS*int'(idx_q) +: NIB_BITS];
  end

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          idx_d   = '0;
          state_d = S_RUN;
`ifdef CLA_SEQ_SUB_EN
          // Subtraction as a + ~b + 1; cin is ignored in that mode.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
        end
      end
      S_RUN: begin
        sum_d[NIB_BITS*int'(idx_q) +: NIB_BITS] = slice_s;
        carry_d = slice_co;
        if (idx_q == IDX_LAST) begin
          // Last nibble: the slice carry is the true carry-out; idx holds.
          cout_d  = slice_co;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed testbench for cla_seq_adder (WIDTH=16).
// Build with +define+CLA_SEQ_SUB_EN to also cover the subtract mode.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
`ifdef CLA_SEQ_SUB_EN
  logic             sub       = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Offer one operation, check latency, hold DONE for 'hold' cycles with
  // out_ready low, then complete the result handshake.
  task automatic run_op(input string name, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb, input logic tc, input logic tsub,
                        input logic [WIDTH:0] expv, input int hold, input bit poke_run);
    logic [WIDTH:0] e;
    int lat;
    exp_q.push_back(expv);
    check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
`ifdef CLA_SEQ_SUB_EN
    sub = tsub;
`else
    if (tsub) $display("note: %s requests sub without CLA_SEQ_SUB_EN", name);
`endif
    step();  // accepting edge
    in_valid = 1'b0;
    a = 16'(($urandom));
    b = 16'(($urandom));
    cin = 1'($urandom_range(0, 1));
    check({name, "_busy_run"}, 32'(busy), 32'd1);
    check({name, "_in_ready_run"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (poke_run && lat == 1) begin
        in_valid = 1'b1;
        a = 16'h7777;
        b = 16'h1111;
      end else begin
        in_valid = 1'b0;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'd4);
    e = exp_q.pop_front();
    check({name, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
    check({name, "_cout"}, 32'(cout), 32'(e[WIDTH]));
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    check({name, "_in_ready_hs"}, 32'(in_ready), 32'd0);
    step();  // result handshake edge
    out_ready = 1'b0;
    check({name, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    check({name, "_busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    step();

    run_op("add_1",     16'h0001, 16'h0000, 1'b0, 1'b0, 17'h00001, 0, 1'b0);
    run_op("ffff_p1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 0, 1'b0);
    run_op("cin_poke",  16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 0, 1'b1);
    // The poked operands must not have produced a second result.
    check("poke_no_extra", 32'(busy), 32'd0);
    run_op("backpress", 16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 5, 1'b0);
    run_op("top_carry", 16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 0, 1'b0);
    run_op("mid_nib",   16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, 0, 1'b0);

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b0;
    step();  // accept; first RUN cycle
    in_valid = 1'b0;
    step();  // second RUN cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 0, 1'b0);
    run_op("sub_pos",  16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 0, 1'b0);
    run_op("sub_off",  16'h0007, 16'h0005, 1'b1, 1'b0, 17'h0000D, 0, 1'b0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
